// File: rtl/demux16_seq_if.sv
// Bundle for demux16_seq: serial bit input side, 16-lane word output side.
// The y_parity signal exists only when DEMUX16_PARITY_EN is defined.
interface demux16_seq_if;
    logic        din;
    logic        din_valid;
    logic        din_ready;
    logic        clr;
    logic [15:0] y;
    logic        y_valid;
    logic        y_ready;
    logic [3:0]  idx;
`ifdef DEMUX16_PARITY_EN
    logic        y_parity;
`endif

    modport slave (
        input  din,
        input  din_valid,
        input  clr,
        input  y_ready,
        output din_ready,
        output y,
        output y_valid,
`ifdef DEMUX16_PARITY_EN
        output y_parity,
`endif
        output idx
    );

    modport master (
        output din,
        output din_valid,
        output clr,
        output y_ready,
        input  din_ready,
        input  y,
        input  y_valid,
`ifdef DEMUX16_PARITY_EN
        input  y_parity,
`endif
        input  idx
    );
endinterface

// File: rtl/demux16_seq.sv
// Serial-to-16-lane demultiplexer: fills lanes 0..15 one accepted bit at a time, then holds
// the word until handed off. Optional registered word parity via macro DEMUX16_PARITY_EN.
module demux16_seq (
    input  logic          clk,
    input  logic          rst_n,
    demux16_seq_if.slave  io
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] y_q, y_d;
    logic [3:0]  idx_q, idx_d;
    logic        accept;

    assign accept = io.din_valid && (state_q == FILL);

    // Next state: clr beats everything; in FULL din is never looked at, so the
    // first bit of the next word can only land after the handoff edge.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        if (io.clr) begin
            state_d = FILL;
            y_d     = 16'h0000;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        y_d[idx_q] = io.din;
                        idx_d      = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (io.y_ready) begin
                        state_d = FILL;
                        y_d     = 16'h0000;
                        idx_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            y_q     <= 16'h0000;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
        end
    end

`ifdef DEMUX16_PARITY_EN
    logic parity_q;

    // Tracks the parity of the next y, so it is zero whenever y is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^y_d;
        end
    end

    assign io.y_parity = parity_q;
`endif

    assign io.y         = y_q;
    assign io.idx       = idx_q;
    assign io.y_valid   = (state_q == FULL);
    assign io.din_ready = (state_q == FILL);

endmodule

// File: tb/tb_demux16_seq.sv
// Self-checking bench for demux16_seq: directed words, expected words queued at issue time
// and popped by an independent monitor on every output handoff.
module tb_demux16_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux16_seq_if bus ();

    demux16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] expQ[$];
    logic [15:0] monExp;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    // One clock of stimulus: inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic b, input logic v);
        bus.din       = b;
        bus.din_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [15:0] w, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(w[i], 1'b1);
            if (gaps) begin
                applyStimulus(1'bx, 1'b0);
                applyStimulus(1'bx, 1'b0);
                checkOutput("gap_idx", 32'(bus.idx), 32'((i + 1) % 16));
            end
        end
    endtask

    // Hand off a held word with din_valid high, which must be ignored.
    task automatic drainWord();
        bus.y_ready = 1'b1;
        applyStimulus(1'b1, 1'b1);
        bus.y_ready   = 1'b0;
        bus.din_valid = 1'b0;
        checkOutput("drain_y", 32'(bus.y), 32'h0000);
        checkOutput("drain_y_valid", 32'(bus.y_valid), 32'd0);
        checkOutput("drain_din_ready", 32'(bus.din_ready), 32'd1);
        checkOutput("drain_idx", 32'(bus.idx), 32'd0);
    endtask

    // Scoreboard monitor: every handoff presented by the DUT consumes one expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_word actual=%h required=none at %0t", bus.y, $time);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("word", 32'(bus.y), 32'(monExp));
`ifdef DEMUX16_PARITY_EN
                checkOutput("word_parity", 32'(bus.y_parity), 32'(^monExp));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr       = 1'b0;
        bus.y_ready   = 1'b0;
        #12;
        checkOutput("rst_y", 32'(bus.y), 32'h0000);
        checkOutput("rst_y_valid", 32'(bus.y_valid), 32'd0);
        checkOutput("rst_din_ready", 32'(bus.din_ready), 32'd1);
        checkOutput("rst_idx", 32'(bus.idx), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] word 0xAF0D with y_ready low");
        sendWord(16'hAF0D, 1'b0);
        checkOutput("full_y", 32'(bus.y), 32'hAF0D);
        checkOutput("full_y_valid", 32'(bus.y_valid), 32'd1);
        checkOutput("full_din_ready", 32'(bus.din_ready), 32'd0);
        checkOutput("full_idx", 32'(bus.idx), 32'd0);
`ifdef DEMUX16_PARITY_EN
        checkOutput("full_parity", 32'(bus.y_parity), 32'd1);
`endif
        expQ.push_back(16'hAF0D);

        $display("[TB] hold FULL for 10 cycles with din_valid high");
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("hold_y", 32'(bus.y), 32'hAF0D);
        checkOutput("hold_y_valid", 32'(bus.y_valid), 32'd1);
        checkOutput("hold_idx", 32'(bus.idx), 32'd0);
        drainWord();

        $display("[TB] clr together with the 6th accept");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("pre_clr_idx", 32'(bus.idx), 32'd5);
        checkOutput("pre_clr_y", 32'(bus.y), 32'h001F);
        bus.clr = 1'b1;
        applyStimulus(1'b1, 1'b1);
        bus.clr       = 1'b0;
        bus.din_valid = 1'b0;
        checkOutput("clr_y", 32'(bus.y), 32'h0000);
        checkOutput("clr_idx", 32'(bus.idx), 32'd0);
        checkOutput("clr_din_ready", 32'(bus.din_ready), 32'd1);
        sendWord(16'h5A3C, 1'b0);
        checkOutput("clean_y", 32'(bus.y), 32'h5A3C);
        checkOutput("clean_y_valid", 32'(bus.y_valid), 32'd1);
        expQ.push_back(16'h5A3C);
        drainWord();

        $display("[TB] word 0xC3A5 with valid gaps");
        sendWord(16'hC3A5, 1'b1);
        checkOutput("gap_y", 32'(bus.y), 32'hC3A5);
        checkOutput("gap_y_valid", 32'(bus.y_valid), 32'd1);
        expQ.push_back(16'hC3A5);
        drainWord();

        $display("[TB] asynchronous reset after 9 accepts");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("pre_rst_idx", 32'(bus.idx), 32'd9);
        bus.din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_y", 32'(bus.y), 32'h0000);
        checkOutput("async_idx", 32'(bus.idx), 32'd0);
        checkOutput("async_y_valid", 32'(bus.y_valid), 32'd0);
        checkOutput("async_din_ready", 32'(bus.din_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] streaming with y_ready and din_valid tied high");
        bus.y_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(16'hFFFF);
        end
        for (int c = 1; c <= 51; c++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("stream_y_valid", 32'(bus.y_valid), 32'((c % 17) == 16));
        end
        bus.y_ready   = 1'b0;
        bus.din_valid = 1'b0;
        checkOutput("stream_end_idx", 32'(bus.idx), 32'd0);
        checkOutput("stream_end_y", 32'(bus.y), 32'h0000);

        $display("[TB] clr while FULL drops the word");
        sendWord(16'h1234, 1'b0);
        checkOutput("pre_clr_full", 32'(bus.y_valid), 32'd1);
        bus.clr = 1'b1;
        applyStimulus(1'b0, 1'b0);
        bus.clr = 1'b0;
        checkOutput("clr_full_y", 32'(bus.y), 32'h0000);
        checkOutput("clr_full_y_valid", 32'(bus.y_valid), 32'd0);
`ifdef DEMUX16_PARITY_EN
        checkOutput("clr_full_parity", 32'(bus.y_parity), 32'd0);
`endif

        applyStimulus(1'b0, 1'b0);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
